// File: rtl/apv_frame_pkg.sv
// Shared constants, FSM state type and word-generation helpers for the APV25 frame emulator.
package apv_frame_pkg;

  localparam int HDR_START_BITS = 3;
  localparam int ADDR_BITS      = 8;
  localparam int HDR_LEN        = 12;
  localparam int N_CHANNELS     = 128;
  localparam int FRAME_LEN      = 140;

  localparam logic [7:0] HDR_LAST_IDX = 8'(HDR_LEN - 1);
  localparam logic [7:0] CH_LAST_IDX  = 8'(N_CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_ANALOG = 2'd2
  } apv_state_e;

  localparam logic [1:0] PAT_BASELINE = 2'd0;
  localparam logic [1:0] PAT_RAMP     = 2'd1;
  localparam logic [1:0] PAT_MARKER   = 2'd2;
  localparam logic [1:0] PAT_ADDR     = 2'd3;

  // Header word idx counts from 0 at the tick slot: start bits, address MSB first, error bit.
  function automatic logic hdr_bit(input logic [7:0] idx, input logic [7:0] addr,
                                   input logic err_inject);
    logic [3:0] sel_s;
    logic       bit_s;
    sel_s = 4'd10 - idx[3:0];
    if (idx < 8'(HDR_START_BITS)) begin
      bit_s = 1'b1;
    end else if (idx < 8'(HDR_START_BITS + ADDR_BITS)) begin
      bit_s = addr[sel_s[2:0]];
    end else begin
      bit_s = ~err_inject;
    end
    return bit_s;
  endfunction

  function automatic logic [11:0] analog_word(input logic [1:0] mode, input logic [7:0] ch,
                                              input logic [11:0] baseline, input logic [6:0] marker,
                                              input logic [7:0] addr);
    logic [11:0] word_s;
    case (mode)
      PAT_BASELINE: word_s = baseline;
      PAT_RAMP:     word_s = baseline + {3'b000, ch[6:0], 2'b00};
      PAT_MARKER:   word_s = (ch[6:0] == marker) ? 12'hFFF : baseline;
      PAT_ADDR:     word_s = baseline + {4'b0000, addr};
      default:      word_s = baseline;
    endcase
    return word_s;
  endfunction

endpackage

// File: rtl/apv_sync_ticker.sv
// Free-running sync tick generator; ticks are SYNC_PERIOD+1 cycles apart while enabled.
module apv_sync_ticker (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [7:0] SYNC_PERIOD,
  output logic       TICK
);

  logic [7:0] period_cnt_r;

  // Held at zero while disabled so the first enabled cycle ticks immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      period_cnt_r <= 8'd0;
    end else if (!ENABLE) begin
      period_cnt_r <= 8'd0;
    end else if (period_cnt_r == 8'd0) begin
      period_cnt_r <= SYNC_PERIOD;
    end else begin
      period_cnt_r <= period_cnt_r - 8'd1;
    end
  end

  assign TICK = ENABLE && (period_cnt_r == 8'd0);

endmodule

// File: rtl/apv_frame_emulator.sv
// APV25 output-stream emulator: sync ticks, 12-word digital header and 128 analog samples
// per frame, presented as a registered 12-bit ADC word.
module apv_frame_emulator
  import apv_frame_pkg::*;
#(
  parameter int PEND_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              TRIGGER,
  input  logic [4:0]        SAMPLE_PER_EVENT,
  input  logic [7:0]        SYNC_PERIOD,
  input  logic [11:0]       HIGH_LEVEL,
  input  logic [11:0]       LOW_LEVEL,
  input  logic [11:0]       BASELINE,
  input  logic [1:0]        PATTERN_MODE,
  input  logic [6:0]        MARKER_CH,
  input  logic              ERR_INJECT,
  output logic [11:0]       APV_DATA,
  output logic              FRAME_ACTIVE,
  output logic              FRAME_DONE,
  output logic [PEND_W-1:0] PENDING,
  output logic              TRIG_LOST,
  output logic [7:0]        FRAME_ADDR
);

  localparam int SUM_W = PEND_W + 6;

  apv_state_e        state_r, state_nxt_s;
  logic [7:0]        idx_r, idx_nxt_s;
  logic              tick_s, start_s, addr_inc_s;
  logic [11:0]       data_r, data_nxt_s;
  logic              active_r, active_nxt_s, done_r, done_nxt_s;
  logic              trig_lost_r, trig_lost_nxt_s;
  logic [PEND_W-1:0] pending_r, pending_nxt_s;
  logic [7:0]        frame_addr_r;
  logic [4:0]        n_s;
  logic [SUM_W-1:0]  pend_sum_s, pend_max_s;

  apv_sync_ticker u_ticker (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .SYNC_PERIOD (SYNC_PERIOD),
    .TICK        (tick_s)
  );

  // Frame sequencing and the word to present next cycle; the tick slot itself carries start bit 0.
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    data_nxt_s   = LOW_LEVEL;
    active_nxt_s = 1'b0;
    done_nxt_s   = 1'b0;
    addr_inc_s   = 1'b0;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && (pending_r != {PEND_W{1'b0}})) begin
          start_s      = 1'b1;
          data_nxt_s   = HIGH_LEVEL;
          active_nxt_s = 1'b1;
          state_nxt_s  = ST_HDR;
          idx_nxt_s    = 8'd1;
        end else if (tick_s) begin
          data_nxt_s = HIGH_LEVEL;
        end else begin
          data_nxt_s = LOW_LEVEL;
        end
      end
      ST_HDR: begin
        active_nxt_s = 1'b1;
        data_nxt_s   = hdr_bit(idx_r, frame_addr_r, ERR_INJECT) ? HIGH_LEVEL : LOW_LEVEL;
        if (idx_r == HDR_LAST_IDX) begin
          state_nxt_s = ST_ANALOG;
          idx_nxt_s   = 8'd0;
        end else begin
          idx_nxt_s = idx_r + 8'd1;
        end
      end
      ST_ANALOG: begin
        active_nxt_s = 1'b1;
        data_nxt_s   = analog_word(PATTERN_MODE, idx_r, BASELINE, MARKER_CH, frame_addr_r);
        if (idx_r == CH_LAST_IDX) begin
          done_nxt_s  = 1'b1;
          addr_inc_s  = 1'b1;
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 8'd0;
        end else begin
          idx_nxt_s = idx_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = 8'd0;
      end
    endcase
  end

  // Pending-frame arithmetic; an overflowing trigger is dropped whole.
  always_comb begin
    if (SAMPLE_PER_EVENT == 5'd0) begin
      n_s = 5'd1;
    end else begin
      n_s = SAMPLE_PER_EVENT;
    end
    pend_max_s      = {6'b000000, {PEND_W{1'b1}}};
    pend_sum_s      = {6'b000000, pending_r} + {{(PEND_W + 1){1'b0}}, n_s}
                    - {{(SUM_W - 1){1'b0}}, start_s};
    trig_lost_nxt_s = 1'b0;
    pending_nxt_s   = pending_r;
    if (!ENABLE) begin
      pending_nxt_s = {PEND_W{1'b0}};
    end else if (TRIGGER && (pend_sum_s > pend_max_s)) begin
      trig_lost_nxt_s = 1'b1;
      pending_nxt_s   = pending_r - {{(PEND_W - 1){1'b0}}, start_s};
    end else if (TRIGGER) begin
      pending_nxt_s = pend_sum_s[PEND_W-1:0];
    end else begin
      pending_nxt_s = pending_r - {{(PEND_W - 1){1'b0}}, start_s};
    end
  end

  // FSM state and word index.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      idx_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Registered outputs, pending counter and frame address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_r       <= 12'd0;
      active_r     <= 1'b0;
      done_r       <= 1'b0;
      trig_lost_r  <= 1'b0;
      pending_r    <= {PEND_W{1'b0}};
      frame_addr_r <= 8'd0;
    end else begin
      data_r       <= data_nxt_s;
      active_r     <= active_nxt_s;
      done_r       <= done_nxt_s;
      trig_lost_r  <= trig_lost_nxt_s;
      pending_r    <= pending_nxt_s;
      frame_addr_r <= addr_inc_s ? (frame_addr_r + 8'd1) : frame_addr_r;
    end
  end

  assign APV_DATA     = data_r;
  assign FRAME_ACTIVE = active_r;
  assign FRAME_DONE   = done_r;
  assign TRIG_LOST    = trig_lost_r;
  assign PENDING      = pending_r;
  assign FRAME_ADDR   = frame_addr_r;

endmodule

// File: doc/apv_frame_emulator.md
# apv_frame_emulator

Generates a cycle-accurate APV25 output stream (sync ticks, digital header, 128 analog samples) as a 12-bit ADC-equivalent word for one readout channel. It sits in place of the ADC parallel data in front of the APV readout channel, for in-system self-test and bench verification of frame decoding, sync detection, sample counting and FIFO back-pressure without a front-end card.

## Interface
Parameters:
- PEND_W, 6, width of the pending-frame counter; maximum pending frames is 2^PEND_W-1.

Ports:
- CLK  in  1  ADC sample clock; all logic is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  emulator run enable.
- TRIGGER  in  1  one-cycle trigger pulse.
- SAMPLE_PER_EVENT  in  5  frames queued per trigger; a value of 0 is treated as 1.
- SYNC_PERIOD  in  8  sync tick spacing minus one, in cycles.
- HIGH_LEVEL, LOW_LEVEL, BASELINE  in  12 each  digital '1', digital '0' and analog baseline levels.
- PATTERN_MODE  in  2  analog pattern select.
- MARKER_CH  in  7  marker channel for pattern mode 2.
- ERR_INJECT  in  1  emit the error bit as '0'.
- APV_DATA  out  12  emulated ADC word.
- FRAME_ACTIVE  out  1  high for the 140 frame words, aligned with APV_DATA.
- FRAME_DONE  out  1  one-cycle pulse with the last analog word.
- PENDING  out  PEND_W  frames still queued.
- TRIG_LOST  out  1  one-cycle pulse when a trigger is dropped.
- FRAME_ADDR  out  8  address of the next frame to be sent.

## Operation
- Sync ticker:
  - Period counter loads SYNC_PERIOD after a tick and decrements otherwise.
  - A tick occurs when the counter is 0 and ENABLE=1, so ticks are spaced SYNC_PERIOD+1 cycles apart. For APV-standard 35-cycle spacing, set SYNC_PERIOD=34.
  - While ENABLE=0 the counter is held at 0, so the first tick comes on the first enabled cycle.
  - The ticker keeps running during frames. Frame length 140 = 4×35 preserves tick phase at SYNC_PERIOD=34.
- Pending counter:
  - When ENABLE=1, TRIGGER adds N=max(SAMPLE_PER_EVENT,1).
  - Each frame start subtracts 1.
  - Trigger and frame start in the same cycle: net change is N-1.
  - If the result would exceed 2^PEND_W-1, the whole trigger is dropped and TRIG_LOST pulses; a frame start in that cycle still decrements.
  - While ENABLE=0 the counter is cleared and triggers are ignored (no TRIG_LOST).
- FSM states: IDLE, HDR, ANALOG.
  - IDLE:
    - Tick with PENDING=0: emit HIGH_LEVEL.
    - Otherwise emit LOW_LEVEL.
    - Tick with PENDING>0 and ENABLE=1: go to HDR, bit counter=0, PENDING decrements, and the tick slot carries the first start bit.
  - HDR, 12 words:
    - Three start '1's.
    - FRAME_ADDR[7:0], MSB first.
    - Error bit: '1' unless ERR_INJECT=1, sampled at the error-bit slot.
    - '1' is emitted as HIGH_LEVEL, '0' as LOW_LEVEL.
  - ANALOG, channels 0..127 in order, per PATTERN_MODE:
    - 0: BASELINE.
    - 1: (BASELINE + 4·ch) mod 4096.
    - 2: 12'hFFF on MARKER_CH, else BASELINE.
    - 3: (BASELINE + address of this frame) mod 4096.
  - After channel 127: FRAME_DONE pulses, FRAME_ADDR increments (mod 256, 255→0), and the FSM returns to IDLE.
- Ticks falling inside a frame are suppressed in the output and do not start frames.
- ENABLE falling mid-frame: the frame completes, then the FSM idles with LOW_LEVEL output and no ticks.

## Timing
- All outputs are registered. The decision in cycle t appears on APV_DATA in cycle t+1.
- Under reset, all outputs are 0, the FSM is in IDLE, the counters are 0 and FRAME_ADDR is 0. The first post-reset word reflects the ENABLE state.
- Trigger to first start bit: the first tick after the trigger is registered. The earliest case is the tick in the cycle after TRIGGER.
- Back-to-back frames: with PENDING>0 at the end of a frame, the next frame starts at the next tick. At SYNC_PERIOD=34 the frames are contiguous.
- FRAME_ACTIVE covers exactly 140 consecutive words per frame. FRAME_DONE coincides with channel 127.
- Level and pattern inputs are sampled every cycle; changing them mid-frame affects subsequent words only.

## Structure
- Package apv_frame_pkg holds:
  - HDR_START_BITS=3, ADDR_BITS=8, HDR_LEN=12, N_CHANNELS=128, FRAME_LEN=140.
  - The FSM state enum.
  - The PATTERN_MODE encodings.
- Sub-module apv_sync_ticker holds the period counter and tick generation (CLK, RST, ENABLE, SYNC_PERIOD → TICK).

## Test plan
- SYNC_PERIOD=34, ENABLE=1, no trigger -> APV_DATA=HIGH_LEVEL exactly every 35 cycles, LOW_LEVEL otherwise, FRAME_ACTIVE=0.
- One TRIGGER, SAMPLE_PER_EVENT=3, PATTERN_MODE=1, BASELINE=0x800 -> three contiguous 140-word frames with addresses 0,1,2; channel 5 is 0x814; three FRAME_DONE pulses; PENDING ends at 0.
- PATTERN_MODE=2, MARKER_CH=64, ERR_INJECT=1 -> header bit 12 is LOW_LEVEL; 0xFFF only at channel 64.
- PEND_W=6, SAMPLE_PER_EVENT=31, three triggers while idle -> PENDING=62; third trigger raises TRIG_LOST and is dropped.
- ENABLE deasserted at channel 40 -> frame completes to channel 127, PENDING=0, output stays LOW_LEVEL with no ticks.
- RST asserted mid-header -> all outputs 0 immediately, FRAME_ADDR=0; after release, first tick on the first enabled cycle.
